// File: rtl/cpu_multicycle.sv
// Multicycle CPU: FETCH/DECODE/EXEC/MEM/WB sequencer over a 16-opcode ISA with a
// synchronous external program ROM and a req/ack data memory with wait states.
module cpu_multicycle #(
    parameter int N     = 8,
    parameter int PSIZE = 8,
    parameter int RADDR = 5,
    parameter int ISIZE = N + 12
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PSIZE-1:0] imem_addr,
    input  logic [ISIZE-1:0] imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [N-1:0]     dmem_addr,
    output logic [N-1:0]     dmem_wdata,
    input  logic [N-1:0]     dmem_rdata,
    input  logic             dmem_ack,
    input  logic [N-1:0]     sw,
    output logic [N-1:0]     outport,
    output logic             out_valid,
    output logic             halted
);
    localparam int NREG = 2 ** RADDR;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [PSIZE-1:0] pc_q, pc_d;
    logic [ISIZE-1:0] ir_q, ir_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d, s_q, s_d, res_q, res_d;
    logic             z_q, z_d, c_q, c_d;
    logic             req_q, req_d, we_q, we_d;
    logic [N-1:0]     addr_q, addr_d, wdata_q, wdata_d, out_q, out_d;
    logic             outv_q, outv_d, halt_q, halt_d;
    logic [N-1:0]     regs_q [NREG];
    logic             rf_we_s;

    logic [3:0]       op_s;
    logic [RADDR-1:0] rd_s, f_rd_s, f_rs1_s, f_rs2_s;
    logic [N-1:0]     imm_s;
    logic [PSIZE-1:0] tgt_s, pc_inc_s;
    logic [N:0]       alu_s;

    assign op_s     = ir_q[ISIZE-1 -: 4];
    assign rd_s     = ir_q[ISIZE-5 -: RADDR];
    assign imm_s    = {{(N-6){ir_q[5]}}, ir_q[5:0]};
    assign tgt_s    = ir_q[PSIZE-1:0];
    assign pc_inc_s = pc_q + PSIZE'(1);
    assign f_rd_s   = imem_data[ISIZE-5 -: RADDR];
    assign f_rs1_s  = imem_data[ISIZE-5-RADDR -: RADDR];
    assign f_rs2_s  = imem_data[RADDR-1:0];

    // ALU with carry/borrow in the top bit; the default arm forms LD/ST addresses.
    always_comb begin
        alu_s = {(N+1){1'b0}};
        case (op_s)
            4'h1:    alu_s = {1'b0, a_q} + {1'b0, b_q};
            4'h2:    alu_s = {1'b0, a_q} - {1'b0, b_q};
            4'h3:    alu_s = {1'b0, a_q & b_q};
            4'h4:    alu_s = {1'b0, a_q | b_q};
            4'h5:    alu_s = {1'b0, a_q ^ b_q};
            4'h6:    alu_s = {1'b0, a_q} + {1'b0, imm_s};
            4'h7:    alu_s = {1'b0, {(N-6){1'b0}}, ir_q[5:0]};
            4'hD:    alu_s = {1'b0, sw};
            default: alu_s = {1'b0, a_q} + {1'b0, imm_s};
        endcase
    end

    // Sequencer next-state: fetch/decode/execute, memory handshake and writeback.
    always_comb begin
        state_d = state_q;  pc_d    = pc_q;    ir_d    = ir_q;
        a_d     = a_q;      b_d     = b_q;     s_d     = s_q;
        res_d   = res_q;    z_d     = z_q;     c_d     = c_q;
        req_d   = req_q;    we_d    = we_q;    addr_d  = addr_q;
        wdata_d = wdata_q;  out_d   = out_q;   outv_d  = 1'b0;
        halt_d  = halt_q;   rf_we_s = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_data;
                a_d     = (f_rs1_s == {RADDR{1'b0}}) ? {N{1'b0}} : regs_q[f_rs1_s];
                b_d     = (f_rs2_s == {RADDR{1'b0}}) ? {N{1'b0}} : regs_q[f_rs2_s];
                s_d     = (f_rd_s  == {RADDR{1'b0}}) ? {N{1'b0}} : regs_q[f_rd_s];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_inc_s;
                res_d   = alu_s[N-1:0];
                state_d = S_FETCH;
                case (op_s)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                        z_d     = (alu_s[N-1:0] == {N{1'b0}});
                        c_d     = alu_s[N];
                        state_d = S_WB;
                    end
                    4'h7, 4'hD: state_d = S_WB;
                    4'h8, 4'h9: begin
                        req_d   = 1'b1;
                        we_d    = (op_s == 4'h9);
                        addr_d  = alu_s[N-1:0];
                        wdata_d = s_q;
                        state_d = S_MEM;
                    end
                    4'hA: pc_d = tgt_s;
                    4'hB: if (z_q) pc_d = pc_inc_s + tgt_s; else pc_d = pc_inc_s;
                    4'hC: if (c_q) pc_d = pc_inc_s + tgt_s; else pc_d = pc_inc_s;
                    4'hE: begin
                        out_d  = a_q;
                        outv_d = 1'b1;
                    end
                    4'hF: begin
                        pc_d    = pc_q;
                        halt_d  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    res_d   = dmem_rdata;
                    state_d = we_q ? S_FETCH : S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                rf_we_s = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural and pipeline-stage registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;          pc_q    <= {PSIZE{1'b0}};  ir_q   <= {ISIZE{1'b0}};
            a_q     <= {N{1'b0}};        b_q     <= {N{1'b0}};      s_q    <= {N{1'b0}};
            res_q   <= {N{1'b0}};        z_q     <= 1'b0;           c_q    <= 1'b0;
            req_q   <= 1'b0;             we_q    <= 1'b0;           addr_q <= {N{1'b0}};
            wdata_q <= {N{1'b0}};        out_q   <= {N{1'b0}};      outv_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;          pc_q    <= pc_d;           ir_q   <= ir_d;
            a_q     <= a_d;              b_q     <= b_d;            s_q    <= s_d;
            res_q   <= res_d;            z_q     <= z_d;            c_q    <= c_d;
            req_q   <= req_d;            we_q    <= we_d;           addr_q <= addr_d;
            wdata_q <= wdata_d;          out_q   <= out_d;          outv_q <= outv_d;
            halt_q  <= halt_d;
        end
    end

    // Register file; r0 is never written so it always reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= {N{1'b0}};
        end else if (rf_we_s && (rd_s != {RADDR{1'b0}})) begin
            regs_q[rd_s] <= res_q;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign outport    = out_q;
    assign out_valid  = outv_q;
    assign halted     = halt_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: ROM/data-memory models, table-driven ALU
// vectors and hand-written programs with an output-port and memory-transaction scoreboard.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [19:0] imem_data;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr, dmem_wdata;
    logic [7:0]  dmem_rdata = 8'h00;
    logic        dmem_ack = 1'b0;
    logic [7:0]  sw;
    logic [7:0]  outport;
    logic        out_valid, halted;

    cpu_multicycle #(.N(8), .PSIZE(8), .RADDR(5), .ISIZE(20)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .sw(sw), .outport(outport), .out_valid(out_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } mtx_t;
    typedef struct { logic [3:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] res; logic c; logic z; } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] rom [256];
    logic [7:0]  dmem [256];
    logic [7:0]  exp_q [$];
    mtx_t        mtx_q [$];
    mtx_t        mt;
    logic [7:0]  pc_hist [$];
    int          pc_cyc [$];
    int          out_cyc [$];
    int          halt_cyc;
    int          ws = 0;
    int          wcnt = 0;
    logic        hold_ack = 1'b0;
    logic        cap_we;
    logic [7:0]  cap_addr, cap_wdata;
    vec_t        vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [5:0] lo);
        return {op, rd, rs1, lo};
    endfunction

    function automatic logic [19:0] enc_t(input logic [3:0] op, input logic [7:0] t);
        return {op, 8'h00, t};
    endfunction

    // Synchronous program ROM.
    always @(posedge clk) imem_data <= rom[imem_addr];

    // Data memory: acks after ws wait cycles and checks the request against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            dmem_ack = 1'b0;
            wcnt     = 0;
        end else if (dmem_ack) begin
            dmem_ack = 1'b0;
            wcnt     = 0;
            chk("req_drop_after_ack", {31'd0, dmem_req}, 32'd0);
        end else if (dmem_req) begin
            if (wcnt == 0) begin
                cap_we = dmem_we; cap_addr = dmem_addr; cap_wdata = dmem_wdata;
                chk("mem_txn_expected", {31'd0, mtx_q.size() > 0}, 32'd1);
                if (mtx_q.size() > 0) begin
                    mt = mtx_q.pop_front();
                    chk("mem_we", {31'd0, dmem_we}, {31'd0, mt.we});
                    chk("mem_addr", {24'd0, dmem_addr}, {24'd0, mt.addr});
                    if (mt.we) chk("mem_wdata", {24'd0, dmem_wdata}, {24'd0, mt.wdata});
                end
            end else begin
                chk("mem_stable", {15'd0, dmem_we, dmem_addr, dmem_wdata},
                    {15'd0, cap_we, cap_addr, cap_wdata});
            end
            if (wcnt == ws && !hold_ack) begin
                dmem_ack = 1'b1;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else dmem_rdata = dmem[dmem_addr];
            end else begin
                wcnt++;
            end
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = enc(4'hF, 5'd0, 5'd0, 6'd0);
        exp_q.delete();
        mtx_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_outport", {24'd0, outport}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_addr_wdata", {16'd0, dmem_addr, dmem_wdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Steps the clock until halted, scoring every out_valid pulse against exp_q.
    task automatic run_prog(input int max_cyc);
        logic [7:0] prev;
        prev = imem_addr;
        pc_hist.delete(); pc_cyc.delete(); out_cyc.delete();
        halt_cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (imem_addr != prev) begin
                pc_hist.push_back(imem_addr);
                pc_cyc.push_back(c);
                prev = imem_addr;
            end
            if (out_valid) begin
                out_cyc.push_back(c);
                chk("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) chk("outport", {24'd0, outport}, {24'd0, exp_q.pop_front()});
            end
            if (halted) begin
                halt_cyc = c;
                break;
            end
        end
        chk("halt_reached", {31'd0, halt_cyc > 0}, 32'd1);
        chk("outs_all_seen", exp_q.size(), 32'd0);
        chk("mem_txns_all_seen", mtx_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        sw    = 8'h00;

        vecs[0] = '{4'h1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{4'h1, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[2] = '{4'h2, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
        vecs[3] = '{4'h2, 8'h33, 8'h33, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{4'h3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[5] = '{4'h4, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
        vecs[6] = '{4'h5, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[7] = '{4'h6, 8'h10, 8'h3F, 8'h0F, 1'b1, 1'b0};
        vecs[8] = '{4'h6, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};

        // ALU vectors: operands come from memory; result, C and Z are reported via OUT.
        for (int i = 0; i < 9; i++) begin
            clear_rom();
            rom[0]  = enc(4'h8, 5'd1, 5'd0, 6'd0);
            rom[1]  = enc(4'h8, 5'd2, 5'd0, 6'd1);
            rom[2]  = (vecs[i].op == 4'h6) ? enc(4'h6, 5'd3, 5'd1, vecs[i].b[5:0])
                                           : enc(vecs[i].op, 5'd3, 5'd1, 6'd2);
            rom[3]  = enc(4'hE, 5'd0, 5'd3, 6'd0);
            rom[4]  = enc(4'h7, 5'd4, 5'd0, 6'd1);
            rom[5]  = enc_t(4'hC, 8'h01);
            rom[6]  = enc(4'h7, 5'd4, 5'd0, 6'd0);
            rom[7]  = enc(4'hE, 5'd0, 5'd4, 6'd0);
            rom[8]  = enc(4'h7, 5'd4, 5'd0, 6'd1);
            rom[9]  = enc_t(4'hB, 8'h01);
            rom[10] = enc(4'h7, 5'd4, 5'd0, 6'd0);
            rom[11] = enc(4'hE, 5'd0, 5'd4, 6'd0);
            dmem[0] = vecs[i].a;
            dmem[1] = vecs[i].b;
            exp_q.push_back(vecs[i].res);
            exp_q.push_back({7'd0, vecs[i].c});
            exp_q.push_back({7'd0, vecs[i].z});
            mtx_q.push_back('{1'b0, 8'h00, 8'h00});
            mtx_q.push_back('{1'b0, 8'h01, 8'h00});
            do_reset();
            run_prog(300);
        end

        // LDI/LDI/ADD/OUT/HALT with per-instruction cycle counts.
        clear_rom();
        rom[0] = enc(4'h7, 5'd1, 5'd0, 6'd5);
        rom[1] = enc(4'h7, 5'd2, 5'd0, 6'd3);
        rom[2] = enc(4'h1, 5'd3, 5'd1, 6'd2);
        rom[3] = enc(4'hE, 5'd0, 5'd3, 6'd0);
        exp_q.push_back(8'h08);
        do_reset();
        run_prog(100);
        chk("pc_change_count_ge3", {31'd0, pc_cyc.size() >= 3}, 32'd1);
        chk("out_count", out_cyc.size(), 32'd1);
        if (pc_cyc.size() >= 3 && out_cyc.size() == 1) begin
            chk("first_exec_cycle", pc_cyc[0], 32'd3);
            chk("ldi1_cycles", pc_cyc[1] - pc_cyc[0], 32'd4);
            chk("ldi2_cycles", pc_cyc[2] - pc_cyc[1], 32'd4);
            chk("add_cycles", out_cyc[0] - pc_cyc[2], 32'd4);
            chk("out_cycles", halt_cyc - out_cyc[0], 32'd3);
        end
        @(posedge clk); #1;
        chk("halt_sticky", {31'd0, halted}, 32'd1);

        // SUB borrow drives BC over LDI r4.
        clear_rom();
        rom[0] = enc(4'h7, 5'd1, 5'd0, 6'd1);
        rom[1] = enc(4'h2, 5'd2, 5'd0, 6'd1);
        rom[2] = enc_t(4'hC, 8'h01);
        rom[3] = enc(4'h7, 5'd4, 5'd0, 6'd9);
        rom[4] = enc(4'hE, 5'd0, 5'd2, 6'd0);
        rom[5] = enc(4'hE, 5'd0, 5'd4, 6'd0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        do_reset();
        run_prog(100);

        // ST then LD with 0 and 3 wait states.
        for (int k = 0; k < 2; k++) begin
            ws = (k == 0) ? 0 : 3;
            clear_rom();
            rom[0] = enc(4'h7, 5'd1, 5'd0, 6'h33);
            rom[1] = enc(4'h9, 5'd1, 5'd0, 6'h10);
            rom[2] = enc(4'h8, 5'd5, 5'd0, 6'h12);
            rom[3] = enc(4'hE, 5'd0, 5'd5, 6'd0);
            dmem[8'h10] = 8'h00;
            dmem[8'h12] = 8'h5A;
            exp_q.push_back(8'h5A);
            mtx_q.push_back('{1'b1, 8'h10, 8'h33});
            mtx_q.push_back('{1'b0, 8'h12, 8'h00});
            do_reset();
            run_prog(200);
            chk("st_mem_written", {24'd0, dmem[8'h10]}, 32'h33);
            chk("ldst_out_cycle", (out_cyc.size() > 0) ? out_cyc[0] : -1, 16 + 2 * ws);
        end
        ws = 0;

        // Countdown loop: body runs three times, then BZ exits to OUT r1.
        clear_rom();
        rom[0] = enc(4'h7, 5'd1, 5'd0, 6'd3);
        rom[1] = enc(4'h6, 5'd1, 5'd1, 6'h3F);
        rom[2] = enc_t(4'hB, 8'h01);
        rom[3] = enc_t(4'hA, 8'h01);
        rom[4] = enc(4'hE, 5'd0, 5'd1, 6'd0);
        exp_q.push_back(8'h00);
        do_reset();
        run_prog(200);
        n = 0;
        foreach (pc_hist[j]) if (pc_hist[j] == 8'd2) n++;
        chk("loop_iters", n, 32'd3);

        // IN/OUT and discarded write to r0.
        sw = 8'hA5;
        clear_rom();
        rom[0] = enc(4'hD, 5'd7, 5'd0, 6'd0);
        rom[1] = enc(4'hE, 5'd0, 5'd7, 6'd0);
        rom[2] = enc(4'h1, 5'd0, 5'd7, 6'd7);
        rom[3] = enc(4'hE, 5'd0, 5'd0, 6'd0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        do_reset();
        run_prog(100);

        // Reset asserted mid-MEM with ack withheld, after setting registers and both flags.
        clear_rom();
        rom[0] = enc(4'h7, 5'd1, 5'd0, 6'h33);
        rom[1] = enc(4'h7, 5'd2, 5'd0, 6'd1);
        rom[2] = enc(4'h6, 5'd3, 5'd2, 6'h3F);
        rom[3] = enc(4'h9, 5'd1, 5'd0, 6'h10);
        mtx_q.push_back('{1'b1, 8'h10, 8'h33});
        hold_ack = 1'b1;
        do_reset();
        n = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (dmem_req) begin
                n = 1;
                break;
            end
        end
        chk("req_seen_before_reset", n, 32'd1);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("req_async_drop", {31'd0, dmem_req}, 32'd0);
        chk("pc_async_clear", {24'd0, imem_addr}, 32'd0);
        hold_ack = 1'b0;
        clear_rom();
        rom[0] = enc(4'hE, 5'd0, 5'd1, 6'd0);
        rom[1] = enc(4'hE, 5'd0, 5'd2, 6'd0);
        rom[2] = enc_t(4'hC, 8'h01);
        rom[3] = enc(4'hE, 5'd0, 5'd2, 6'd0);
        rom[4] = enc_t(4'hB, 8'h01);
        rom[5] = enc(4'hE, 5'd0, 5'd1, 6'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("pc_after_release", {24'd0, imem_addr}, 32'd0);
        run_prog(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multicycle successor to the single-cycle 8-bit CPU top.
- Runs a fixed 16-opcode ISA through an explicit FETCH/DECODE/EXEC/MEM/WB state machine, one instruction at a time.
- Program ROM is external and synchronous.
- Data memory is external, reached through a req/ack handshake with arbitrary wait states.
- Switch input and a registered output port with a valid strobe replace the address-gated outport.

Parameters:
- N, 8: data/register width (≥6).
- PSIZE, 8: program address width.
- RADDR, 5: register address width; 2**RADDR registers, r0 reads as zero.
- ISIZE, N+12: instruction width (must be ≥4+2*RADDR+6 and ≥4+PSIZE).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  PSIZE  program ROM address (= PC).
- imem_data  in  ISIZE  ROM data, valid the cycle after imem_addr is presented.
- dmem_req  out  1  data memory request, held until ack.
- dmem_we  out  1  1=store, 0=load; valid while req.
- dmem_addr  out  N  data address; valid while req.
- dmem_wdata  out  N  store data; valid while req.
- dmem_rdata  in  N  load data, valid in the ack cycle.
- dmem_ack  in  1  one-cycle completion pulse.
- sw  in  N  switch input for IN.
- outport  out  N  registered output, written by OUT.
- out_valid  out  1  one-cycle pulse when outport is updated.
- halted  out  1  high in HALT state.

Behaviour:
- Instruction fields:
  - op = I[ISIZE-1 -: 4]
  - rd = next RADDR bits
  - rs1 = next RADDR bits
  - rs2 = I[RADDR-1:0]
  - imm6 = I[5:0], sign-extended to N
  - target = I[PSIZE-1:0]
- Opcodes (all arithmetic is modulo 2**N):
  - 0 NOP
  - 1 ADD rd=rs1+rs2
  - 2 SUB rd=rs1-rs2
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 ADDI rd=rs1+imm6
  - 7 LDI rd=zext(I[5:0])
  - 8 LD rd=mem[rs1+imm6]
  - 9 ST mem[rs1+imm6]=rd
  - A JMP PC=target
  - B BZ: if Z, PC=PC+1+sext(target)
  - C BC: if C, PC=PC+1+sext(target)
  - D IN rd=sw
  - E OUT outport=rs1
  - F HALT
- Flags Z and C update only on ops 1-6.
  - C = carry out for ADD/ADDI.
  - C = borrow (rs1<rs2 unsigned) for SUB.
  - C = 0 for logic ops.
  - Z = (result==0).
- State machine:
  - FETCH: imem_addr=PC.
  - DECODE: IR<=imem_data; register file read.
  - EXEC: ALU result and address computed, flags latched, branch resolved.
  - MEM: only LD/ST.
  - WB: register write.
- Transitions:
  - ALU/LDI/IN: FETCH→DECODE→EXEC→WB→FETCH, 4 cycles.
  - NOP, OUT, JMP, BZ, BC: FETCH→DECODE→EXEC→FETCH, 3 cycles.
  - LD: EXEC→MEM→WB.
  - ST: EXEC→MEM→FETCH.
  - HALT: EXEC→HALT, terminal until reset.
- PC update:
  - PC increments by 1 in EXEC unless a branch is taken; it wraps at 2**PSIZE.
  - Relative branch uses the signed PSIZE-bit offset, wraps modulo 2**PSIZE.
  - Not-taken branch falls through to PC+1.
- Handshake:
  - dmem_req rises on MEM entry, together with stable we/addr/wdata.
  - req, we, addr and wdata stay constant until the cycle dmem_ack is sampled high.
  - req deasserts the next cycle; LD captures dmem_rdata in the ack cycle.
  - Ack arriving in the first MEM cycle gives a 1-cycle MEM.
  - No timeout; ack outside MEM is ignored.
- Writes to r0 are discarded; r0 always reads 0.
- OUT:
  - outport<=rs1 in EXEC; out_valid pulses that same clock edge for exactly 1 cycle.
  - outport holds its value otherwise.
- Reset (asynchronous, any state, including mid-MEM):
  - Cleared to 0: PC, IR, flags, all registers, outport, out_valid, halted.
  - dmem_req drops immediately.
  - State returns to FETCH; execution resumes at address 0 the first clock after release.
- Reset values of the remaining outputs: imem_addr=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.

Test Plan:
- ROM: LDI r1,5; LDI r2,3; ADD r3,r1,r2; OUT r3; HALT → out_valid pulses once with outport=0x08.
  - Instruction cycle counts 4,4,4,3; halted=1 thereafter.
- LDI r1,1; SUB r2,r0,r1; BC +1; LDI r4,9; OUT r2 → r2=0xFF, C=1 so branch skips LDI r4.
  - outport=0xFF and r4 stays 0.
- ST then LD with 0 and 3 wait states, using memory model mem[0x12]=0x5A:
  - ST r1(=0x33) to 0x10 → req held through ack with addr/wdata stable; req low the cycle after ack.
  - LD r5,[r0+0x12] → r5=0x5A.
- Loop LDI r1,3; ADDI r1,r1,-1; BZ +1; JMP 1; OUT r1 → loop body executes 3 times; outport=0x00.
- Assert reset during MEM with ack withheld → dmem_req falls asynchronously; after release, imem_addr=0 and all registers and flags read 0.
- sw=0xA5; IN r7; OUT r7; ADD r0,r7,r7; OUT r0 → outport=0xA5 then 0x00, proving r0 is not written.
